// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, 3-sample majority per bit, LSB-first
// deserialization, optional parity check and registered one-cycle result strobes.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_Data,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error,
  output logic                  Busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic                  rx_meta, rx_s;
  logic [5:0]            edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  samp_a, samp_b, bit_val;
  logic                  par_en_q, par_typ_q, par_fail;
  logic                  resolve, stop_bad;

  logic [5:0] half;
  logic       last_edge;
  logic       vote;

  assign half      = {1'b0, Prescale[5:1]};
  assign last_edge = (edge_cnt == Prescale - 6'd1);
  assign vote      = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      samp_a       <= 1'b1;
      samp_b       <= 1'b1;
      bit_val      <= 1'b1;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_fail     <= 1'b0;
      resolve      <= 1'b0;
      stop_bad     <= 1'b0;
      P_Data       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      resolve      <= 1'b0;
      Busy         <= (state != IDLE);

      // Frame verdict is issued one cycle after STOP exits, so it can overlap
      // the detection cycle of a back-to-back start bit.
      if (resolve) begin
        Stop_Error   <= stop_bad;
        Parity_Error <= par_fail;
        if (!stop_bad && !par_fail) begin
          Data_Valid <= 1'b1;
          P_Data     <= shreg;
        end
      end

      if (state != IDLE) begin
        edge_cnt <= last_edge ? 6'd0 : edge_cnt + 6'd1;
        if (edge_cnt == half - 6'd1) samp_a  <= rx_s;
        if (edge_cnt == half)        samp_b  <= rx_s;
        if (edge_cnt == half + 6'd1) bit_val <= vote;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state     <= START;
            edge_cnt  <= 6'd1;
            bit_cnt   <= '0;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_fail  <= 1'b0;
          end
        end
        START: begin
          if (last_edge) state <= bit_val ? IDLE : DATA;
        end
        DATA: begin
          if (last_edge) begin
            shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (last_edge) begin
            par_fail <= (bit_val != (^shreg ^ par_typ_q));
            state    <= STOP;
          end
        end
        STOP: begin
          if (last_edge) begin
            state    <= IDLE;
            resolve  <= 1'b1;
            stop_bad <= ~bit_val;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames from the test plan plus
// randomized frames compared against a frame-level reference model.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_Data;
  logic       Data_Valid, Parity_Error, Stop_Error, Busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] exp_pdata = 8'h00;

  typedef struct {
    int         c;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] d;
  } ev_t;

  ev_t  evq[$];
  int   brise[$];
  int   bfall[$];
  logic bprev = 1'b0;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_Data(P_Data),
    .Data_Valid(Data_Valid), .Parity_Error(Parity_Error),
    .Stop_Error(Stop_Error), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // cyc is the index of the most recent rising edge; outputs sampled 1ns later
  always begin
    @(posedge CLK);
    cyc++;
    #1;
    if (Data_Valid || Parity_Error || Stop_Error)
      evq.push_back('{cyc, Data_Valid, Parity_Error, Stop_Error, P_Data});
    if (Busy && !bprev) brise.push_back(cyc);
    if (!Busy && bprev) bfall.push_back(cyc);
    bprev = Busy;
  end

  // Called right after a rising edge; returns right at a rising edge.
  // t0 is the first edge that samples the start bit low.
  task automatic send_frame(input int p, input logic [7:0] d, input logic pen,
                            input logic pbit, input logic stop, input logic scr,
                            output int t0);
    #1 RX_IN = 1'b0;
    t0 = cyc + 1;
    repeat (p) @(posedge CLK);
    if (scr) begin
      PAR_EN  = ~PAR_EN;
      PAR_TYP = ~PAR_TYP;
    end
    for (int i = 0; i < 8; i++) begin
      #1 RX_IN = d[i];
      repeat (p) @(posedge CLK);
    end
    if (pen) begin
      #1 RX_IN = pbit;
      repeat (p) @(posedge CLK);
    end
    #1 RX_IN = stop;
    repeat (p) @(posedge CLK);
  endtask

  task automatic idle(input int n);
    #1 RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
  endtask

  task automatic clear_q();
    evq.delete();
    brise.delete();
    bfall.delete();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (P_Data !== 8'h00) begin failures++; $display("FAIL reset_pdata got=%h exp=00", P_Data); end
    checks++; if ({Data_Valid, Parity_Error, Stop_Error, Busy} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {Data_Valid, Parity_Error, Stop_Error, Busy}); end
    #2 RST = 1'b1;
    repeat (4) @(posedge CLK);
    clear_q();
  endtask

  task automatic test_basic();
    int t0;
    ev_t ev;
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_q();
    send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    idle(8);
    exp_pdata = 8'hA5;
    checks++; if (evq.size() !== 1) begin failures++; $display("FAIL basic_events got=%0d exp=1", evq.size()); end
    ev = (evq.size() > 0) ? evq[0] : '{-1, 1'b0, 1'b0, 1'b0, 8'h00};
    checks++; if (ev.c !== t0 + 82) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", ev.c - t0, 82); end
    checks++; if ({ev.dv, ev.pe, ev.se} !== 3'b100) begin failures++; $display("FAIL basic_strobes got=%b exp=100", {ev.dv, ev.pe, ev.se}); end
    checks++; if (ev.d !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", ev.d); end
    checks++; if (brise.size() < 1 || brise[0] !== t0 + 3) begin
      failures++; $display("FAIL basic_busy_rise got=%0d exp=%0d", (brise.size() > 0) ? brise[0] - t0 : -1, 3); end
    checks++; if (bfall.size() < 1 || bfall[0] !== t0 + 82) begin
      failures++; $display("FAIL basic_busy_fall got=%0d exp=%0d", (bfall.size() > 0) ? bfall[0] - t0 : -1, 82); end
  endtask

  task automatic test_parity();
    int t0;
    ev_t ev;
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    clear_q();
    send_frame(16, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, t0);
    idle(8);
    exp_pdata = 8'h0F;
    ev = (evq.size() > 0) ? evq[0] : '{-1, 1'b0, 1'b0, 1'b0, 8'h00};
    checks++; if (evq.size() !== 1 || {ev.dv, ev.pe, ev.se} !== 3'b100 || ev.d !== 8'h0F) begin
      failures++; $display("FAIL parity_good got n=%0d s=%b d=%h exp n=1 s=100 d=0f", evq.size(), {ev.dv, ev.pe, ev.se}, ev.d); end
    clear_q();
    send_frame(16, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, t0);
    idle(8);
    ev = (evq.size() > 0) ? evq[0] : '{-1, 1'b0, 1'b0, 1'b0, 8'h00};
    checks++; if (evq.size() !== 1 || {ev.dv, ev.pe, ev.se} !== 3'b010) begin
      failures++; $display("FAIL parity_bad got n=%0d s=%b exp n=1 s=010", evq.size(), {ev.dv, ev.pe, ev.se}); end
    checks++; if (ev.c !== t0 + 178) begin failures++; $display("FAIL parity_latency got=%0d exp=178", ev.c - t0); end
    checks++; if (P_Data !== exp_pdata) begin failures++; $display("FAIL parity_hold got=%h exp=%h", P_Data, exp_pdata); end
  endtask

  task automatic test_stop_error();
    int t0;
    ev_t ev;
    Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_q();
    send_frame(16, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, t0);
    idle(8);
    ev = (evq.size() > 0) ? evq[0] : '{-1, 1'b0, 1'b0, 1'b0, 8'h00};
    checks++; if (evq.size() !== 1 || {ev.dv, ev.pe, ev.se} !== 3'b001 || ev.c !== t0 + 162) begin
      failures++; $display("FAIL stop_err got n=%0d s=%b lat=%0d exp n=1 s=001 lat=162", evq.size(), {ev.dv, ev.pe, ev.se}, ev.c - t0); end
    checks++; if (P_Data !== exp_pdata) begin failures++; $display("FAIL stop_hold got=%h exp=%h", P_Data, exp_pdata); end
    clear_q();
    send_frame(16, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    idle(8);
    exp_pdata = 8'h81;
    ev = (evq.size() > 0) ? evq[0] : '{-1, 1'b0, 1'b0, 1'b0, 8'h00};
    checks++; if (evq.size() !== 1 || {ev.dv, ev.pe, ev.se} !== 3'b100 || P_Data !== 8'h81) begin
      failures++; $display("FAIL stop_next got n=%0d s=%b d=%h exp n=1 s=100 d=81", evq.size(), {ev.dv, ev.pe, ev.se}, P_Data); end
  endtask

  task automatic test_glitch();
    int g0, t0;
    Prescale = 6'd16; PAR_EN = 1'b0;
    clear_q();
    #1 RX_IN = 1'b0;
    g0 = cyc + 1;
    repeat (3) @(posedge CLK);
    idle(40);
    checks++; if (evq.size() !== 0) begin failures++; $display("FAIL glitch_strobes got=%0d exp=0", evq.size()); end
    checks++; if (brise.size() !== 1 || bfall.size() !== 1 || brise[0] !== g0 + 3 || bfall[0] !== g0 + 18) begin
      failures++; $display("FAIL glitch_busy got rise=%0d fall=%0d exp rise=3 fall=18",
        (brise.size() > 0) ? brise[0] - g0 : -1, (bfall.size() > 0) ? bfall[0] - g0 : -1); end
    clear_q();
    send_frame(16, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    idle(8);
    exp_pdata = 8'h5A;
    checks++; if (evq.size() !== 1 || P_Data !== 8'h5A) begin
      failures++; $display("FAIL glitch_next got n=%0d d=%h exp n=1 d=5a", evq.size(), P_Data); end
  endtask

  task automatic test_back_to_back();
    int ta, tb;
    Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    clear_q();
    send_frame(32, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, ta);
    send_frame(32, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, tb);
    idle(8);
    exp_pdata = 8'hAA;
    checks++; if (evq.size() !== 2) begin failures++; $display("FAIL b2b_events got=%0d exp=2", evq.size()); end
    if (evq.size() == 2) begin
      checks++; if (evq[1].c - evq[0].c !== 352) begin failures++; $display("FAIL b2b_spacing got=%0d exp=352", evq[1].c - evq[0].c); end
      checks++; if (evq[0].d !== 8'h55 || evq[1].d !== 8'hAA || !evq[0].dv || !evq[1].dv) begin
        failures++; $display("FAIL b2b_data got=%h,%h dv=%b%b exp=55,aa dv=11", evq[0].d, evq[1].d, evq[0].dv, evq[1].dv); end
      checks++; if (evq[0].c !== ta + 354) begin failures++; $display("FAIL b2b_latency got=%0d exp=354", evq[0].c - ta); end
    end
  endtask

  task automatic test_reset_midframe();
    int t0, c0;
    Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_q();
    c0 = cyc;
    fork
      send_frame(16, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
      begin
        while (cyc < c0 + 1 + 5 * 16 + 8) @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        checks++; if ({P_Data, Data_Valid, Parity_Error, Stop_Error, Busy} !== 12'h000) begin
          failures++; $display("FAIL rst_mid_outputs got d=%h flags=%b exp d=00 flags=0000",
            P_Data, {Data_Valid, Parity_Error, Stop_Error, Busy}); end
        repeat (2) @(posedge CLK);
        #3 RST = 1'b1;
      end
    join
    idle(60);
    exp_pdata = 8'h00;
    checks++; if (evq.size() !== 0) begin failures++; $display("FAIL rst_mid_strobes got=%0d exp=0", evq.size()); end
    clear_q();
    send_frame(16, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    idle(8);
    exp_pdata = 8'hC3;
    checks++; if (evq.size() !== 1 || P_Data !== 8'hC3 || evq[0].c !== t0 + 162) begin
      failures++; $display("FAIL rst_mid_next got n=%0d d=%h exp n=1 d=c3", evq.size(), P_Data); end
  endtask

  task automatic test_random();
    int t0, p, lat;
    logic [7:0] d;
    logic pen, ptyp, pbit, stop, perr, scr;
    ev_t ev;
    for (int n = 0; n < 12; n++) begin
      p    = 2 * $urandom_range(3, 16);
      d    = 8'($urandom);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      perr = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      scr  = 1'($urandom);
      pbit = (^d) ^ ptyp ^ perr;
      Prescale = 6'(p); PAR_EN = pen; PAR_TYP = ptyp;
      clear_q();
      send_frame(p, d, pen, pbit, stop, scr, t0);
      idle(6);
      perr = pen & perr;
      lat  = 2 + p * (10 + (pen ? 1 : 0));
      if (!perr && stop) exp_pdata = d;
      ev = (evq.size() > 0) ? evq[0] : '{-1, 1'b0, 1'b0, 1'b0, 8'h00};
      checks++; if (evq.size() !== 1 || ev.c !== t0 + lat) begin
        failures++; $display("FAIL rand%0d_timing p=%0d got n=%0d lat=%0d exp n=1 lat=%0d", n, p, evq.size(), ev.c - t0, lat); end
      checks++; if ({ev.dv, ev.pe, ev.se} !== {~perr & stop, perr, ~stop}) begin
        failures++; $display("FAIL rand%0d_strobes got=%b exp=%b", n, {ev.dv, ev.pe, ev.se}, {~perr & stop, perr, ~stop}); end
      checks++; if (P_Data !== exp_pdata) begin failures++; $display("FAIL rand%0d_pdata got=%h exp=%h", n, P_Data, exp_pdata); end
    end
  endtask

  initial begin
    @(posedge CLK);
    test_reset();
    test_basic();
    test_parity();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
